// File: rtl/esm_dwell_reporter.sv
// -----------------------------------------------------------------------------
// esm_dwell_reporter
// Transmit side of the dwell metadata path. Watches the dwell strobe coming
// from esm_dwell_controller and, for every completed dwell, emits one fixed
// 14-word AXI-stream report with the dwell metadata, the measured dwell length
// and the start timestamp. Single clock domain; CDC lives in the downstream FIFO.
//
// Ports
//   Clk                 clock (Clk_x4 domain)
//   Rst                 synchronous active-high reset
//   Enable              1 = capture new dwells; sampled at dwell start only
//   Dwell_active        high for the duration of a dwell
//   Dwell_data          dwell metadata, stable while Dwell_active
//   Dwell_sequence_num  dwell sequence number, stable while Dwell_active
//   M_axis_valid        report beat valid
//   M_axis_ready        downstream ready
//   M_axis_data         report beat
//   M_axis_last         high on word 13
//   Dropped_count       saturating count of dwells lost to a full pending slot
// -----------------------------------------------------------------------------

package esm_dwell_reporter_pkg;

    typedef struct packed {
        logic [15:0] frequency;
        logic [15:0] tag;
        logic [31:0] duration;
        logic [7:0]  fast_lock_profile;
        logic [7:0]  gain;
        logic [7:0]  threshold_shift_wide;
        logic [7:0]  threshold_shift_narrow;
        logic [63:0] channel_mask_narrow;
        logic [15:0] min_pulse_duration;
        logic [7:0]  channel_mask_wide;
    } esm_dwell_metadata_t;

endpackage

module esm_dwell_reporter
    import esm_dwell_reporter_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 32,   // only 32 is supported
    parameter logic [31:0] REPORT_MAGIC   = 32'h45534D52,
    parameter logic [7:0]  MODULE_ID      = 8'h02,
    parameter logic [7:0]  MESSAGE_TYPE   = 8'h10
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Enable,
    input  logic                      Dwell_active,
    input  esm_dwell_metadata_t       Dwell_data,
    input  logic [31:0]               Dwell_sequence_num,
    output logic                      M_axis_valid,
    input  logic                      M_axis_ready,
    output logic [AXI_DATA_WIDTH-1:0] M_axis_data,
    output logic                      M_axis_last,
    output logic [15:0]               Dropped_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'd13;

    // Free-running timestamp
    logic [63:0]         ts_r;

    // Dwell tracking and shadow capture
    logic                active_prev_r;
    logic                captured_r;
    esm_dwell_metadata_t sh_data_r;
    logic [31:0]         sh_dseq_r;
    logic [63:0]         sh_ts_r;
    logic [31:0]         act_cnt_r;

    // Single pending-report slot
    logic                pend_valid_r;
    esm_dwell_metadata_t pend_data_r;
    logic [31:0]         pend_dseq_r;
    logic [63:0]         pend_ts_r;
    logic [31:0]         pend_cnt_r;

    logic [31:0]         rpt_seq_r;
    logic [15:0]         dropped_r;

    // FSM and registered stream outputs
    state_t              state_r;
    state_t              state_nx_s;
    logic [3:0]          word_idx_r;
    logic [3:0]          word_idx_nx_s;
    logic                valid_r;
    logic                valid_nx_s;
    logic [31:0]         data_r;
    logic [31:0]         data_nx_s;
    logic                last_r;
    logic                last_nx_s;

    logic                beat_acc_s;
    logic                last_acc_s;
    logic                dwell_start_s;
    logic                dwell_fall_s;
    logic                dwell_end_s;
    logic                pend_load_s;
    logic                dwell_drop_s;

    // Report word map: selects word idx of the report built from the pending slot.
    function automatic logic [31:0] report_word(
        input logic [3:0]          idx,
        input logic [31:0]         seq,
        input esm_dwell_metadata_t md,
        input logic [31:0]         dseq,
        input logic [31:0]         cnt,
        input logic [63:0]         ts
    );
        logic [31:0] w;
        case (idx)
            4'd0:    w = REPORT_MAGIC;
            4'd1:    w = seq;
            4'd2:    w = {MODULE_ID, MESSAGE_TYPE, 16'h0000};
            4'd3:    w = dseq;
            4'd4:    w = {md.frequency, md.tag};
            4'd5:    w = md.duration;
            4'd6:    w = {16'h0000, md.fast_lock_profile, md.gain};
            4'd7:    w = {16'h0000, md.threshold_shift_wide, md.threshold_shift_narrow};
            4'd8:    w = md.channel_mask_narrow[31:0];
            4'd9:    w = md.channel_mask_narrow[63:32];
            4'd10:   w = {md.min_pulse_duration, 8'h00, md.channel_mask_wide};
            4'd11:   w = cnt;
            4'd12:   w = ts[31:0];
            4'd13:   w = ts[63:32];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign beat_acc_s    = valid_r & M_axis_ready;
    assign last_acc_s    = beat_acc_s & last_r;
    assign dwell_start_s = Dwell_active & ~active_prev_r & Enable;
    assign dwell_fall_s  = ~Dwell_active & active_prev_r;
    // A falling edge only counts when its start was captured (Enable=1, no reset since).
    assign dwell_end_s   = dwell_fall_s & captured_r;
    // The slot is reusable in the very cycle its last beat leaves.
    assign pend_load_s   = dwell_end_s & (~pend_valid_r | last_acc_s);
    assign dwell_drop_s  = dwell_end_s & ~pend_load_s;

    // Timestamp counter, wraps modulo 2^64.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_r <= 64'd0;
        end else begin
            ts_r <= ts_r + 64'd1;
        end
    end

    // Dwell edge tracking, shadow capture and active-cycle counting.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // Track the live strobe through reset so a dwell already in
            // progress when reset releases is not seen as a new start.
            active_prev_r <= Dwell_active;
            captured_r    <= 1'b0;
            sh_data_r     <= '0;
            sh_dseq_r     <= 32'd0;
            sh_ts_r       <= 64'd0;
            act_cnt_r     <= 32'd0;
        end else begin
            active_prev_r <= Dwell_active;
            if (dwell_start_s) begin
                captured_r <= 1'b1;
                sh_data_r  <= Dwell_data;
                sh_dseq_r  <= Dwell_sequence_num;
                sh_ts_r    <= ts_r;
                act_cnt_r  <= 32'd1;
            end else begin
                if (dwell_fall_s) begin
                    captured_r <= 1'b0;
                end
                if (Dwell_active && (act_cnt_r != 32'hFFFF_FFFF)) begin
                    act_cnt_r <= act_cnt_r + 32'd1;
                end
            end
        end
    end

    // Pending-report slot: loaded at dwell end, freed when word 13 is accepted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= '0;
            pend_dseq_r  <= 32'd0;
            pend_ts_r    <= 64'd0;
            pend_cnt_r   <= 32'd0;
        end else if (pend_load_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= sh_data_r;
            pend_dseq_r  <= sh_dseq_r;
            pend_ts_r    <= sh_ts_r;
            pend_cnt_r   <= act_cnt_r;
        end else if (last_acc_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Report sequence number and saturating drop counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rpt_seq_r <= 32'd0;
            dropped_r <= 16'd0;
        end else begin
            if (last_acc_s) begin
                rpt_seq_r <= rpt_seq_r + 32'd1;
            end
            if (dwell_drop_s && (dropped_r != 16'hFFFF)) begin
                dropped_r <= dropped_r + 16'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Always pass through IDLE so valid drops for a cycle between packets.
                if (last_acc_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered stream outputs.
    always_comb begin
        valid_nx_s    = valid_r;
        data_nx_s     = data_r;
        last_nx_s     = last_r;
        word_idx_nx_s = word_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    valid_nx_s    = 1'b1;
                    word_idx_nx_s = 4'd0;
                    data_nx_s     = report_word(4'd0, rpt_seq_r, pend_data_r,
                                                pend_dseq_r, pend_cnt_r, pend_ts_r);
                    last_nx_s     = 1'b0;
                end else begin
                    valid_nx_s    = 1'b0;
                    word_idx_nx_s = 4'd0;
                    data_nx_s     = 32'd0;
                    last_nx_s     = 1'b0;
                end
            end
            ST_SEND: begin
                if (beat_acc_s) begin
                    if (last_r) begin
                        valid_nx_s    = 1'b0;
                        word_idx_nx_s = 4'd0;
                        data_nx_s     = 32'd0;
                        last_nx_s     = 1'b0;
                    end else begin
                        word_idx_nx_s = word_idx_r + 4'd1;
                        data_nx_s     = report_word(word_idx_r + 4'd1, rpt_seq_r, pend_data_r,
                                                    pend_dseq_r, pend_cnt_r, pend_ts_r);
                        last_nx_s     = ((word_idx_r + 4'd1) == LAST_WORD);
                    end
                end else begin
                    // Stalled beat: hold everything stable.
                    valid_nx_s    = valid_r;
                    word_idx_nx_s = word_idx_r;
                    data_nx_s     = data_r;
                    last_nx_s     = last_r;
                end
            end
            default: begin
                valid_nx_s    = 1'b0;
                word_idx_nx_s = 4'd0;
                data_nx_s     = 32'd0;
                last_nx_s     = 1'b0;
            end
        endcase
    end

    // Registered stream outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_r    <= 1'b0;
            data_r     <= 32'd0;
            last_r     <= 1'b0;
            word_idx_r <= 4'd0;
        end else begin
            valid_r    <= valid_nx_s;
            data_r     <= data_nx_s;
            last_r     <= last_nx_s;
            word_idx_r <= word_idx_nx_s;
        end
    end

    assign M_axis_valid  = valid_r;
    assign M_axis_data   = data_r;
    assign M_axis_last   = last_r;
    assign Dropped_count = dropped_r;

endmodule

// File: tb/tb_esm_dwell_reporter.sv
// -----------------------------------------------------------------------------
// tb_esm_dwell_reporter
// Directed sequence with randomized metadata, dwell lengths and ready patterns.
// Expected reports are built from the report layout into a word queue at each
// dwell end; a monitor compares every accepted beat and checks stream rules.
// -----------------------------------------------------------------------------

module tb_esm_dwell_reporter;
    import esm_dwell_reporter_pkg::*;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                Enable;
    logic                Dwell_active;
    esm_dwell_metadata_t Dwell_data;
    logic [31:0]         Dwell_sequence_num;
    logic                M_axis_valid;
    logic                M_axis_ready;
    logic [31:0]         M_axis_data;
    logic                M_axis_last;
    logic [15:0]         Dropped_count;

    always #5 Clk = ~Clk;

    esm_dwell_reporter dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .Enable             (Enable),
        .Dwell_active       (Dwell_active),
        .Dwell_data         (Dwell_data),
        .Dwell_sequence_num (Dwell_sequence_num),
        .M_axis_valid       (M_axis_valid),
        .M_axis_ready       (M_axis_ready),
        .M_axis_data        (M_axis_data),
        .M_axis_last        (M_axis_last),
        .Dropped_count      (Dropped_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0]         exp_words[$];
    int                  rd_ptr = 0;
    int                  beat_idx = 0;
    logic [63:0]         edge_cnt = 64'd0;   // cycles since reset released
    logic [31:0]         rpt_seq = 32'd0;
    logic [15:0]         model_drop = 16'd0;
    int                  rdy_mode = 0;       // 0: ready=1, 1: ready=0, 2: random 30%

    esm_dwell_metadata_t cur_meta;
    logic [31:0]         cur_dseq;
    logic [63:0]         cur_ts;
    logic                cur_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    function automatic esm_dwell_metadata_t rand_meta();
        esm_dwell_metadata_t m;
        logic [31:0] r0, r1, r2, r3;
        r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
        m.frequency              = r0[15:0];
        m.tag                    = r0[31:16];
        m.duration               = $urandom;
        m.fast_lock_profile      = r1[7:0];
        m.gain                   = r1[15:8];
        m.threshold_shift_wide   = r1[23:16];
        m.threshold_shift_narrow = r1[31:24];
        m.channel_mask_narrow    = {r2, r3};
        m.min_pulse_duration     = r0[23:8];
        m.channel_mask_wide      = r3[7:0] ^ r2[15:8];
        return m;
    endfunction

    // Expected report: 14 words laid out as the downstream parser reads them.
    task automatic push_report(input logic [31:0] seq, input esm_dwell_metadata_t m,
                               input logic [31:0] dseq, input logic [31:0] cnt,
                               input logic [63:0] ts);
        exp_words.push_back(32'h45534D52);
        exp_words.push_back(seq);
        exp_words.push_back(32'h0210_0000);
        exp_words.push_back(dseq);
        exp_words.push_back({m.frequency, m.tag});
        exp_words.push_back(m.duration);
        exp_words.push_back({16'h0000, m.fast_lock_profile, m.gain});
        exp_words.push_back({16'h0000, m.threshold_shift_wide, m.threshold_shift_narrow});
        exp_words.push_back(m.channel_mask_narrow[31:0]);
        exp_words.push_back(m.channel_mask_narrow[63:32]);
        exp_words.push_back({m.min_pulse_duration, 8'h00, m.channel_mask_wide});
        exp_words.push_back(cnt);
        exp_words.push_back(ts[31:0]);
        exp_words.push_back(ts[63:32]);
    endtask

    task automatic begin_dwell_now(input esm_dwell_metadata_t m, input logic [31:0] dseq,
                                   input logic en);
        Dwell_data         = m;
        Dwell_sequence_num = dseq;
        Enable             = en;
        Dwell_active       = 1'b1;
        cur_meta = m;
        cur_dseq = dseq;
        cur_en   = en;
        cur_ts   = edge_cnt;
    endtask

    task automatic start_dwell(input esm_dwell_metadata_t m, input logic [31:0] dseq,
                               input logic en);
        hold(1);
        begin_dwell_now(m, dseq, en);
    endtask

    // Dwell end: reported if the pending slot is free at the end edge
    // (including a last beat leaving on that same edge), otherwise dropped.
    task automatic end_dwell();
        logic [63:0] len;
        len = edge_cnt - cur_ts;
        Dwell_active = 1'b0;
        if (cur_en) begin
            if (rd_ptr == exp_words.size()) begin
                push_report(rpt_seq, cur_meta, cur_dseq, len[31:0], cur_ts);
                rpt_seq = rpt_seq + 32'd1;
            end else if (model_drop != 16'hFFFF) begin
                model_drop = model_drop + 16'd1;
            end
        end
    endtask

    task automatic run_dwell(input int len, input logic en);
        start_dwell(rand_meta(), $urandom, en);
        hold(len);
        end_dwell();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (((rd_ptr != exp_words.size()) || M_axis_valid) && (n < budget)) begin
            hold(1);
            n++;
        end
        check(tag, 64'(exp_words.size() - rd_ptr), 64'd0);
    endtask

    always @(posedge Clk) edge_cnt <= Rst ? 64'd0 : edge_cnt + 64'd1;

    // Downstream ready generator
    initial begin
        M_axis_ready = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       M_axis_ready = 1'b1;
                1:       M_axis_ready = 1'b0;
                default: M_axis_ready = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    // Stream monitor
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;
    logic        prev_last  = 1'b0;
    logic        after_last = 1'b0;

    initial begin
        forever begin
            @(negedge Clk);
            if (Rst) begin
                rd_ptr     = exp_words.size();
                beat_idx   = 0;
                prev_stall = 1'b0;
                after_last = 1'b0;
                check("rst_valid", 64'(M_axis_valid), 64'd0);
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(M_axis_valid), 64'd1);
                    check("hold_data", 64'(M_axis_data), 64'(prev_data));
                    check("hold_last", 64'(M_axis_last), 64'(prev_last));
                end
                if (after_last) begin
                    check("gap_valid", 64'(M_axis_valid), 64'd0);
                end
                after_last = 1'b0;
                if (M_axis_valid) begin
                    if (rd_ptr >= exp_words.size()) begin
                        check("unexpected_beat", 64'(M_axis_valid), 64'd0);
                    end else if (M_axis_ready) begin
                        check($sformatf("beat_data_w%0d", beat_idx), 64'(M_axis_data),
                              64'(exp_words[rd_ptr]));
                        check($sformatf("beat_last_w%0d", beat_idx), 64'(M_axis_last),
                              64'(beat_idx == 13));
                        rd_ptr++;
                        if (beat_idx == 13) begin
                            beat_idx   = 0;
                            after_last = 1'b1;
                        end else begin
                            beat_idx++;
                        end
                    end
                end else if (beat_idx != 0) begin
                    check("valid_mid_packet", 64'(M_axis_valid), 64'd1);
                end
                prev_stall = M_axis_valid & ~M_axis_ready;
                prev_data  = M_axis_data;
                prev_last  = M_axis_last;
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        esm_dwell_metadata_t m;
        logic found;
        int n;

        Rst = 1'b1;
        Enable = 1'b1;
        Dwell_active = 1'b0;
        Dwell_data = '0;
        Dwell_sequence_num = 32'd0;
        hold(3);
        check("reset_valid", 64'(M_axis_valid), 64'd0);
        check("reset_last", 64'(M_axis_last), 64'd0);
        check("reset_data", 64'(M_axis_data), 64'd0);
        check("reset_dropped", 64'(Dropped_count), 64'd0);
        Rst = 1'b0;
        hold(2);

        // 1. Single dwell, 50 cycles, ready=1; valid rises 2 cycles after the fall
        rdy_mode = 0;
        m = rand_meta();
        m.tag = 16'h1234;
        m.frequency = 16'h0ABC;
        start_dwell(m, 32'hA5A5_0001, 1'b1);
        hold(50);
        end_dwell();
        hold(1);
        check("t1_valid_1cyc", 64'(M_axis_valid), 64'd0);
        hold(1);
        check("t1_valid_2cyc", 64'(M_axis_valid), 64'd1);
        wait_drain("t1_drain", 100);

        // 2. Backpressure with ready high ~30% of cycles
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            run_dwell($urandom_range(1, 20), 1'b1);
            hold($urandom_range(0, 30));
        end
        wait_drain("t2_drain", 3000);
        check("t2_dropped", 64'(Dropped_count), 64'(model_drop));

        // 3. Overflow: three dwells complete while ready=0
        rdy_mode = 1;
        hold(2);
        for (int i = 0; i < 3; i++) begin
            run_dwell(10, 1'b1);
            hold(2);
        end
        hold(3);
        check("t3_dropped", 64'(Dropped_count), 64'(model_drop));
        rdy_mode = 0;
        wait_drain("t3_drain", 200);
        run_dwell(4, 1'b1);
        wait_drain("t3_next_drain", 100);

        // 4. Dwell ends on the same edge word 13 is accepted
        rdy_mode = 0;
        run_dwell(5, 1'b1);
        start_dwell(rand_meta(), $urandom, 1'b1);
        found = 1'b0;
        n = 0;
        while (!found && (n < 100)) begin
            hold(1);
            n++;
            found = M_axis_valid & M_axis_ready & M_axis_last;
        end
        check("t4_sync_found", 64'(found), 64'd1);
        end_dwell();
        hold(3);
        check("t4_no_drop", 64'(Dropped_count), 64'(model_drop));
        wait_drain("t4_drain", 100);

        // 5. Reset while word 6 is on the bus
        rdy_mode = 0;
        run_dwell(8, 1'b1);
        found = 1'b0;
        n = 0;
        while (!found && (n < 100)) begin
            hold(1);
            n++;
            found = (beat_idx == 6);
        end
        check("t5_word6_found", 64'(found), 64'd1);
        hold(1);
        Rst = 1'b1;
        rpt_seq = 32'd0;
        model_drop = 16'd0;
        hold(1);
        check("t5_valid_after_rst", 64'(M_axis_valid), 64'd0);
        hold(1);
        Rst = 1'b0;
        begin_dwell_now(rand_meta(), $urandom, 1'b1);
        hold(12);
        check("t5_dropped_cleared", 64'(Dropped_count), 64'd0);
        end_dwell();
        wait_drain("t5_drain", 100);

        // 6. Enable=0 at one dwell start, Enable=1 at the next
        start_dwell(rand_meta(), 32'h0000_0600, 1'b0);
        hold(2);
        Enable = 1'b1;
        hold(8);
        end_dwell();
        hold(3);
        check("t6_ignored_valid", 64'(M_axis_valid), 64'd0);
        start_dwell(rand_meta(), 32'h0000_0601, 1'b1);
        hold(7);
        end_dwell();
        wait_drain("t6_drain", 100);

        // 7. Random back-to-back dwells under random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            run_dwell($urandom_range(1, 25), ($urandom_range(0, 9) < 8));
            hold($urandom_range(0, 3));
        end
        wait_drain("t7_drain", 3000);
        check("t7_dropped", 64'(Dropped_count), 64'(model_drop));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
